sseg_scan: RTL
==============

# sseg_scan

Digit-scan driver for the Basys3 4-digit 7-segment display. It samples the gear selection (drive / neutral / reverse) and filters it for stability. It then time-multiplexes the four anodes and presents one anode select plus its character pattern per scan slot on `an_sel` / `char_sel`. The display output stage downstream consumes these signals and applies backtrack override and per-digit validation.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (≥ 4). At 100 MHz this gives 1 ms per digit.
- `STABLE_CYCLES`, default 1000000: consecutive cycles a new valid gear code must hold before acceptance (≥ 1).
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with all anodes off, for anti-ghosting (< `REFRESH_DIV`).

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset. Asynchronous and active-high.
- `gear_in` input 2: raw gear code, asynchronous to `clk`. 2'b00 = neutral, 2'b01 = drive, 2'b10 = reverse, 2'b11 = invalid.
- `an_sel` output 4: anode select, active-low, registered.
- `char_sel` output 7: segment pattern {g,f,e,d,c,b,a}, active-low, registered.
- `gear_q` output 2: currently accepted gear code, registered.
- `slot_tick` output 1: single-cycle pulse, registered, marking the start of each digit slot.

## Operation
- Input sync: `gear_in` passes through a 2-flop synchronizer to give `gear_s`.
- Stability filter, using candidate register `cand` and counter `stab_cnt`:
  - If `gear_s` != `cand`: `cand` <= `gear_s` and `stab_cnt` <= 0.
  - Else, if `stab_cnt` < `STABLE_CYCLES`-1: `stab_cnt` increments.
  - Else, if `cand` != 2'b11: `gear_q` <= `cand`. The counter saturates.
  - Code 2'b11 is never accepted; `gear_q` holds its previous value indefinitely.
- Refresh divider:
  - `div_cnt` counts 0..`REFRESH_DIV`-1 and wraps.
  - On wrap, `digit_idx` (2 bits) increments modulo 4.
  - `slot_tick` is asserted in the cycle after the wrap edge.
- Anode decode by `digit_idx`: 0 → 4'b1110, 1 → 4'b1101, 2 → 4'b1011, 3 → 4'b0111.
- Character decode:
  - idx 2 shows D (7'b0100001) iff `gear_q` = drive.
  - idx 1 shows N (7'b0101011) iff `gear_q` = neutral.
  - idx 0 shows R (7'b0101111) iff `gear_q` = reverse.
  - idx 3 always shows 7'b1111111. This digit is reserved for the downstream backtrack indicator.
  - Every other combination shows 7'b1111111.
- Blanking: while `div_cnt` < `BLANK_CYCLES`, the `an_sel` register loads 4'b1111 and `char_sel` loads 7'b1111111.
- Output registers load the decode of the current `div_cnt`, `digit_idx` and `gear_q` every cycle.

## Timing
- Reset values:
  - `an_sel` = 4'b1111
  - `char_sel` = 7'b1111111
  - `gear_q` = 2'b00 (neutral)
  - `slot_tick` = 0
  - `div_cnt` = 0, `digit_idx` = 0, `stab_cnt` = 0
  - `cand` = 2'b00
  - synchronizer flops = 2'b00
- Reset asserted mid-slot or mid-filter clears everything immediately, without waiting for a clock edge.
- Output latency:
  - `an_sel` / `char_sel` reflect the state one cycle after it changes.
  - First non-blank anode: `an_sel` = 4'b1110 appears on the edge after `div_cnt` reaches `BLANK_CYCLES`.
- Full scan period: 4·`REFRESH_DIV` cycles. Each anode is active for `REFRESH_DIV`−`BLANK_CYCLES` cycles per scan.
- Gear acceptance latency: 2 sync cycles, plus 1 cycle for the `cand` load, plus `STABLE_CYCLES` cycles, measured from a stable `gear_in` change to `gear_q` update.
- A `gear_in` glitch shorter than `STABLE_CYCLES` never changes `gear_q`.
- A gear change during a slot takes effect on `char_sel` the cycle after `gear_q` updates. There is no wait for the slot boundary.
- At most one bit of `an_sel` is low in any cycle. When `digit_idx` advances, an all-high cycle always appears in between (`BLANK_CYCLES` ≥ 1), or the change is direct (`BLANK_CYCLES` = 0).

## Test plan
Parameters for all scenarios: `REFRESH_DIV` = 8, `STABLE_CYCLES` = 4, `BLANK_CYCLES` = 1.

1. Reset then run 40 cycles with `gear_in` = 00:
   - Each slot is 1 cycle of 1111 followed by 7 cycles of the anode code.
   - Anodes sequence 1110 → 1101 → 1011 → 0111.
   - `char_sel` = 0101011 only during 1101; 1111111 otherwise.
   - `slot_tick` pulses every 8 cycles.
2. `gear_in` 00 → 01, held:
   - `gear_q` = 01 exactly 7 cycles after the change.
   - The D pattern 0100001 then appears only on `an_sel` = 1011.
3. `gear_in` = 10 pulsed for 3 cycles, then back to 00: `gear_q` stays 00 and no R pattern is ever output.
4. `gear_in` = 11 held for 20 cycles: `gear_q` retains its prior value (01), and the display is unchanged.
5. Reverse accepted, then `rst` asserted mid-slot (`div_cnt` = 5):
   - Outputs go to 1111 / 1111111 and `gear_q` = 00 asynchronously.
   - After release, the scan restarts at `digit_idx` 0 with the blank cycle first.
6. Over any 200-cycle random-gear run, `an_sel` is never 1111 for more than 1 consecutive cycle outside reset, and never has more than one bit low.

Source files
------------

// File: rtl/sseg_scan.sv
// -----------------------------------------------------------------------------
// sseg_scan
//   Digit-scan driver for a 4-digit, common-anode 7-segment display.
//   The raw gear code is synchronised and filtered for stability. The four
//   anodes are then time-multiplexed, with a short all-off window at the start
//   of each digit slot to suppress ghosting.
//
// Ports
//   clk       in   1  system clock
//   rst       in   1  asynchronous, active-high reset
//   gear_in   in   2  raw gear code (async): 00 neutral, 01 drive, 10 reverse,
//                     11 invalid
//   an_sel    out  4  anode select, active-low, registered
//   char_sel  out  7  segment pattern {g,f,e,d,c,b,a}, active-low, registered
//   gear_q    out  2  accepted (filtered) gear code, registered
//   slot_tick out  1  one-cycle pulse at the start of each digit slot
// -----------------------------------------------------------------------------
module sseg_scan #(
  parameter int REFRESH_DIV   = 100000,
  parameter int STABLE_CYCLES = 1000000,
  parameter int BLANK_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] gear_in,
  output logic [3:0] an_sel,
  output logic [6:0] char_sel,
  output logic [1:0] gear_q,
  output logic       slot_tick
);

  // The stability counter is sized for STABLE_CYCLES+1 so that
  // STABLE_CYCLES = 1 still yields a non-zero width.
  localparam int DIV_W  = $clog2(REFRESH_DIV);
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0]  BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] GEAR_NEU = 2'b00;
  localparam logic [1:0] GEAR_DRV = 2'b01;
  localparam logic [1:0] GEAR_REV = 2'b10;
  localparam logic [1:0] GEAR_INV = 2'b11;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_N   = 7'b0101011;
  localparam logic [6:0] SEG_R   = 7'b0101111;

  logic [1:0]        gear_meta_r;
  logic [1:0]        gear_sync_r;
  logic [1:0]        cand_r;
  logic [STAB_W-1:0] stab_cnt_r;
  logic [1:0]        gear_q_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [1:0]        digit_idx_r;
  logic              slot_tick_r;
  logic [3:0]        an_sel_r;
  logic [6:0]        char_sel_r;
  logic [3:0]        an_next_s;
  logic [6:0]        char_next_s;

  // One-hot-low anode code for a digit position.
  function automatic logic [3:0] anode_decode(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = 4'b1110;
      2'd1:    an = 4'b1101;
      2'd2:    an = 4'b1011;
      2'd3:    an = 4'b0111;
      default: an = AN_OFF;
    endcase
    return an;
  endfunction

  // Each gear letter owns one digit position. Digit 3 is left dark here
  // because the downstream stage overlays its backtrack indicator there.
  function automatic logic [6:0] char_decode(input logic [1:0] idx,
                                             input logic [1:0] gear);
    logic [6:0] pat;
    pat = SEG_OFF;
    case (idx)
      2'd0: begin
        if (gear == GEAR_REV) pat = SEG_R;
        else                  pat = SEG_OFF;
      end
      2'd1: begin
        if (gear == GEAR_NEU) pat = SEG_N;
        else                  pat = SEG_OFF;
      end
      2'd2: begin
        if (gear == GEAR_DRV) pat = SEG_D;
        else                  pat = SEG_OFF;
      end
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

  // Two-flop synchroniser for the asynchronous gear code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gear_meta_r <= 2'b00;
      gear_sync_r <= 2'b00;
    end else begin
      gear_meta_r <= gear_in;
      gear_sync_r <= gear_meta_r;
    end
  end

  // Stability filter: a candidate must hold STABLE_CYCLES cycles before it
  // is accepted. The invalid code can become a candidate but is never accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_r     <= GEAR_NEU;
      stab_cnt_r <= {STAB_W{1'b0}};
      gear_q_r   <= GEAR_NEU;
    end else if (gear_sync_r != cand_r) begin
      cand_r     <= gear_sync_r;
      stab_cnt_r <= {STAB_W{1'b0}};
    end else if (stab_cnt_r < STAB_LAST) begin
      stab_cnt_r <= stab_cnt_r + STAB_W'(1);
    end else if (cand_r != GEAR_INV) begin
      gear_q_r <= cand_r;
    end
  end

  // Slot divider and digit index. slot_tick rises in the first cycle of
  // each new slot (the cycle in which div_cnt reads 0 again).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r   <= {DIV_W{1'b0}};
      digit_idx_r <= 2'd0;
      slot_tick_r <= 1'b0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r   <= {DIV_W{1'b0}};
      digit_idx_r <= digit_idx_r + 2'd1;
      slot_tick_r <= 1'b1;
    end else begin
      div_cnt_r   <= div_cnt_r + DIV_W'(1);
      slot_tick_r <= 1'b0;
    end
  end

  // Next display value: dark during the blanking window, otherwise the
  // anode and letter of the current digit.
  always_comb begin
    an_next_s   = AN_OFF;
    char_next_s = SEG_OFF;
    if (div_cnt_r < BLANK_END) begin
      an_next_s   = AN_OFF;
      char_next_s = SEG_OFF;
    end else begin
      an_next_s   = anode_decode(digit_idx_r);
      char_next_s = char_decode(digit_idx_r, gear_q_r);
    end
  end

  // Display output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_sel_r   <= AN_OFF;
      char_sel_r <= SEG_OFF;
    end else begin
      an_sel_r   <= an_next_s;
      char_sel_r <= char_next_s;
    end
  end

  assign an_sel    = an_sel_r;
  assign char_sel  = char_sel_r;
  assign gear_q    = gear_q_r;
  assign slot_tick = slot_tick_r;

endmodule
